// File: rtl/spike_rate_decoder.sv
// Counts spikes over a 2^WINDOW_LOG2-cycle window and converts the count to an intensity value.
// Optional first-spike-time outputs are enabled with SPIKE_DECODER_FIRST_SPIKE_EN.
module spike_rate_decoder #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned WINDOW_LOG2 = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   spike_in,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_value,
   output logic [WINDOW_LOG2:0]   out_count,
   output logic                   overrun,
   input  logic                   overrun_clr
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
   ,
   output logic [WINDOW_LOG2-1:0] first_spike_time,
   output logic                   no_spike
`endif
);

   localparam int unsigned SHIFT = WIDTH - WINDOW_LOG2;

   typedef enum logic [0:0] {StIdle, StCount} state_e;

   state_e                 state_q, state_d;
   logic [WINDOW_LOG2:0]   cyc_q, cyc_d;
   logic [WINDOW_LOG2:0]   spk_q, spk_d;
   logic                   window_end;
   logic                   load;
   logic                   valid_q, valid_d;
   logic [WIDTH-1:0]       value_q, value_d;
   logic [WINDOW_LOG2:0]   count_q, count_d;
   logic                   overrun_q, overrun_d;
   logic [WIDTH-1:0]       conv_value;

   // Cycle counter runs 0..N-1 while sampling; reaching N (MSB set) marks the result cycle.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      spk_d      = spk_q;
      window_end = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCount;
               cyc_d   = '0;
               spk_d   = '0;
            end
         end
         StCount: begin
            if (cyc_q[WINDOW_LOG2]) begin
               state_d    = StIdle;
               window_end = 1'b1;
            end else begin
               cyc_d = cyc_q + 1'b1;
               spk_d = spk_q + (WINDOW_LOG2 + 1)'(spike_in);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cyc_q   <= '0;
         spk_q   <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         spk_q   <= spk_d;
      end
   end

   // A full window (count == N) saturates instead of wrapping to zero.
   always_comb begin
      if (spk_q[WINDOW_LOG2]) begin
         conv_value = '1;
      end else begin
         conv_value = WIDTH'(spk_q[WINDOW_LOG2-1:0]) << SHIFT;
      end
   end

   assign load = window_end && (!valid_q || out_ready);

   always_comb begin
      valid_d   = valid_q;
      value_d   = value_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         value_d = conv_value;
         count_d = spk_q;
      end
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (window_end && valid_q && !out_ready) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         value_q   <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         value_q   <= value_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   assign busy      = (state_q == StCount);
   assign out_valid = valid_q;
   assign out_value = value_q;
   assign out_count = count_q;
   assign overrun   = overrun_q;

`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
   logic [WINDOW_LOG2-1:0] fst_q, fst_d;
   logic                   seen_q, seen_d;
   logic [WINDOW_LOG2-1:0] fst_out_q, fst_out_d;
   logic                   no_spike_q, no_spike_d;

   always_comb begin
      fst_d      = fst_q;
      seen_d     = seen_q;
      fst_out_d  = fst_out_q;
      no_spike_d = no_spike_q;
      if (state_q == StIdle && start) begin
         fst_d  = '1;
         seen_d = 1'b0;
      end else if (state_q == StCount && !cyc_q[WINDOW_LOG2] && spike_in && !seen_q) begin
         fst_d  = cyc_q[WINDOW_LOG2-1:0];
         seen_d = 1'b1;
      end
      if (load) begin
         fst_out_d  = fst_q;
         no_spike_d = !seen_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fst_q      <= '0;
         seen_q     <= 1'b0;
         fst_out_q  <= '0;
         no_spike_q <= 1'b0;
      end else begin
         fst_q      <= fst_d;
         seen_q     <= seen_d;
         fst_out_q  <= fst_out_d;
         no_spike_q <= no_spike_d;
      end
   end

   assign first_spike_time = fst_out_q;
   assign no_spike         = no_spike_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder (WIDTH=16, WINDOW_LOG2=8).
module tb_spike_rate_decoder;

   localparam int unsigned WIDTH       = 16;
   localparam int unsigned WINDOW_LOG2 = 8;
   localparam int unsigned N           = 1 << WINDOW_LOG2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   start = 1'b1;
   logic                   spike_in = 1'b1;
   logic                   busy;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [WIDTH-1:0]       out_value;
   logic [WINDOW_LOG2:0]   out_count;
   logic                   overrun;
   logic                   overrun_clr = 1'b0;
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
   logic [WINDOW_LOG2-1:0] first_spike_time;
   logic                   no_spike;
`endif

   int total = 0;
   int bad   = 0;

   spike_rate_decoder #(
      .WIDTH       (WIDTH),
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .spike_in         (spike_in),
      .busy             (busy),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_value        (out_value),
      .out_count        (out_count),
      .overrun          (overrun),
      .overrun_clr      (overrun_clr)
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
      ,
      .first_spike_time (first_spike_time),
      .no_spike         (no_spike)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 none, 1 every sample, 2 every 4th sample, 3 only sample 5
   task automatic run_window(input int kind, input logic ready_end);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         case (kind)
            1:       spike_in = 1'b1;
            2:       spike_in = (i % 4 == 0);
            3:       spike_in = (i == 5);
            default: spike_in = 1'b0;
         endcase
         tick();
      end
      spike_in = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_last_sample: got %b want 1", busy);
      end
      out_ready = ready_end;
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_after_end: got %b want 0", busy);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if ({busy, out_valid, out_value, out_count, overrun} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b valid=%b value=%h count=%0d ovr=%b want all 0",
                  busy, out_valid, out_value, out_count, overrun);
      end
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
      total++;
      if ({first_spike_time, no_spike} !== '0) begin
         bad++;
         $display("FAIL reset_first_spike: got %h/%b want 0/0", first_spike_time, no_spike);
      end
`endif
      rst      = 1'b0;
      start    = 1'b0;
      spike_in = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got busy=%b valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_full_window();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_at_start: got %b want 1", busy);
      end
      for (int i = 0; i < int'(N); i++) begin
         spike_in = 1'b1;
         tick();
      end
      spike_in = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_early: got %b want 0 at k+256", out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd256 || out_value !== 16'hFFFF || busy !== 1'b0)
      begin
         bad++;
         $display("FAIL full_window: got valid=%b count=%0d value=%h busy=%b want 1 256 ffff 0",
                  out_valid, out_count, out_value, busy);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL valid_fall: got %b want 0", out_valid);
      end
   endtask

   task automatic test_sparse();
      run_window(2, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd64 || out_value !== 16'h4000) begin
         bad++;
         $display("FAIL sparse_window: got valid=%b count=%0d value=%h want 1 64 4000",
                  out_valid, out_count, out_value);
      end
      run_window(0, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd0 || out_value !== 16'h0000) begin
         bad++;
         $display("FAIL empty_window: got valid=%b count=%0d value=%h want 1 0 0000",
                  out_valid, out_count, out_value);
      end
      tick();
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      run_window(1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd256 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL held_first: got valid=%b count=%0d ovr=%b want 1 256 0",
                  out_valid, out_count, overrun);
      end
      run_window(2, 1'b0);
      total++;
      if (overrun !== 1'b1 || out_count !== 9'd256 || out_value !== 16'hFFFF) begin
         bad++;
         $display("FAIL overrun_drop: got ovr=%b count=%0d value=%h want 1 256 ffff",
                  overrun, out_count, out_value);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL transfer_sticky: got valid=%b ovr=%b want 0 1", out_valid, overrun);
      end
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_clr: got %b want 0", overrun);
      end
      run_window(1, 1'b0);
      run_window(2, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd64 || out_value !== 16'h4000 || overrun !== 1'b0)
      begin
         bad++;
         $display("FAIL same_edge_load: got valid=%b count=%0d value=%h ovr=%b want 1 64 4000 0",
                  out_valid, out_count, out_value, overrun);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_after_load: got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid_window();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         spike_in = 1'b1;
         tick();
      end
      rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got busy=%b valid=%b want 0 0", busy, out_valid);
      end
      spike_in = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
      end
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL no_result_after_reset: got busy=%b valid=%b want 0 0", busy, out_valid);
      end
      run_window(2, 1'b1);
      total++;
      if (out_valid !== 1'b1 || out_count !== 9'd64 || out_value !== 16'h4000) begin
         bad++;
         $display("FAIL window_after_reset: got valid=%b count=%0d value=%h want 1 64 4000",
                  out_valid, out_count, out_value);
      end
      tick();
   endtask

`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
   task automatic test_first_spike();
      out_ready = 1'b1;
      run_window(3, 1'b1);
      total++;
      if (first_spike_time !== 8'd5 || no_spike !== 1'b0 || out_count !== 9'd1 ||
          out_value !== 16'h0100) begin
         bad++;
         $display("FAIL first_spike_5: got t=%0d none=%b count=%0d value=%h want 5 0 1 0100",
                  first_spike_time, no_spike, out_count, out_value);
      end
      run_window(0, 1'b1);
      total++;
      if (first_spike_time !== 8'hFF || no_spike !== 1'b1) begin
         bad++;
         $display("FAIL first_spike_empty: got t=%h none=%b want ff 1", first_spike_time, no_spike);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_full_window();
      test_sparse();
      test_overrun();
      test_reset_mid_window();
`ifdef SPIKE_DECODER_FIRST_SPIKE_EN
      test_first_spike();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
